// File: rtl/cu_neander.sv
// Control unit for the Neander accumulator CPU: fetch/decode/execute FSM (T0..T7, HALT).
// Optional macro CU_MEM_WAIT_EN adds mem_ready and stalls every memory state until it is high.
module cu_neander (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       flag_n,
    input  logic       flag_z,
`ifdef CU_MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       load_pc,
    output logic       inc_pc,
    output logic       sel,
    output logic       load_rem,
    output logic       load_rdm,
    output logic       load_ri,
    output logic       load_ac,
    output logic       load_nz,
    output logic       mem_read,
    output logic       mem_write,
    output logic [2:0] alu_op,
    output logic       halted
);

    typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

    state_t state;
    logic   ready;
    logic   mem_state;
    logic   stall;
    logic   is_mem_op;
    logic   jump_taken;

`ifdef CU_MEM_WAIT_EN
    assign ready = mem_ready;
`else
    assign ready = 1'b1;
`endif

    // T1, T4 and T6 are the only states that strobe memory on every path that reaches them.
    assign mem_state  = (state == T1) || (state == T4) || (state == T6);
    assign stall      = mem_state && !ready;
    assign is_mem_op  = (opcode >= 4'h1) && (opcode <= 4'h5);
    assign jump_taken = (opcode == 4'h8) || ((opcode == 4'h9) && flag_n) ||
                        ((opcode == 4'hA) && flag_z);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= T0;
        end else if (!stall) begin
            case (state)
                T0: state <= T1;
                T1: state <= T2;
                T2: state <= T3;
                T3: begin
                    if (is_mem_op)
                        state <= T4;
                    else if (opcode == 4'hF)
                        state <= HALT;
                    else if (jump_taken)
                        state <= T4;
                    else
                        state <= T0;
                end
                T4: state <= T5;
                T5: state <= is_mem_op ? T6 : T0;
                T6: state <= (opcode == 4'h1) ? T0 : T7;
                T7: state <= T0;
                HALT: state <= HALT;
                default: state <= T0;
            endcase
        end
    end

    always_comb begin
        load_pc   = 1'b0;
        inc_pc    = 1'b0;
        sel       = 1'b0;
        load_rem  = 1'b0;
        load_rdm  = 1'b0;
        load_ri   = 1'b0;
        load_ac   = 1'b0;
        load_nz   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_op    = 3'b000;
        halted    = 1'b0;
        // Reset silences every output, even in the cycle the state register is already T0.
        if (!rst) begin
            case (state)
                T0: load_rem = 1'b1;
                T1: begin
                    mem_read = 1'b1;
                    load_rdm = 1'b1;
                    inc_pc   = ready;
                end
                T2: load_ri = 1'b1;
                T3: begin
                    if (is_mem_op) begin
                        load_rem = 1'b1;
                    end else if (opcode == 4'h6) begin
                        load_ac = 1'b1;
                        load_nz = 1'b1;
                        alu_op  = 3'b011;
                    end else if ((opcode >= 4'h8) && (opcode <= 4'hA)) begin
                        if (jump_taken)
                            load_rem = 1'b1;
                        else
                            inc_pc = 1'b1;
                    end
                end
                T4: begin
                    mem_read = 1'b1;
                    load_rdm = 1'b1;
                    inc_pc   = is_mem_op && ready;
                end
                T5: begin
                    if (is_mem_op) begin
                        sel      = 1'b1;
                        load_rem = 1'b1;
                    end else begin
                        load_pc = 1'b1;
                    end
                end
                T6: begin
                    sel = 1'b1;
                    if (opcode == 4'h1) begin
                        mem_write = 1'b1;
                    end else begin
                        mem_read = 1'b1;
                        load_rdm = 1'b1;
                    end
                end
                T7: begin
                    load_ac = 1'b1;
                    load_nz = 1'b1;
                    case (opcode)
                        4'h2:    alu_op = 3'b100;
                        4'h4:    alu_op = 3'b001;
                        4'h5:    alu_op = 3'b010;
                        default: alu_op = 3'b000;
                    endcase
                end
                HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cu_neander.sv
// Randomized bench for cu_neander: per-instruction micro-step lists built from the ISA rules,
// compared cycle by cycle against the DUT outputs (with random mem_ready when CU_MEM_WAIT_EN is set).
module tb_cu_neander;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       flag_n;
    logic       flag_z;
    logic       mem_ready;
    logic       load_pc, inc_pc, sel, load_rem, load_rdm, load_ri;
    logic       load_ac, load_nz, mem_read, mem_write, halted;
    logic [2:0] alu_op;

    always #5 clk = ~clk;

    cu_neander dut (
        .clk(clk), .rst(rst), .opcode(opcode), .flag_n(flag_n), .flag_z(flag_z),
`ifdef CU_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .load_pc(load_pc), .inc_pc(inc_pc), .sel(sel), .load_rem(load_rem),
        .load_rdm(load_rdm), .load_ri(load_ri), .load_ac(load_ac), .load_nz(load_nz),
        .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op), .halted(halted)
    );

    localparam logic [13:0] LPC = 14'h2000, INC = 14'h1000, SEL = 14'h0800, REM = 14'h0400;
    localparam logic [13:0] RDM = 14'h0200, RI  = 14'h0100, AC  = 14'h0080, NZ  = 14'h0040;
    localparam logic [13:0] MR  = 14'h0020, MW  = 14'h0010, HLT = 14'h0008;

    logic [13:0] obs;
    assign obs = {load_pc, inc_pc, sel, load_rem, load_rdm, load_ri, load_ac, load_nz,
                  mem_read, mem_write, halted, alu_op};

    logic [13:0] exp_q[$];
    bit          mem_q[$];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic void push(input logic [13:0] v, input bit m);
        exp_q.push_back(v);
        mem_q.push_back(m);
    endfunction

    // Micro-step list for one instruction, straight from the ISA description.
    function automatic void build(input logic [3:0] op, input bit fn3, input bit fz3);
        logic [13:0] alu;
        push(REM, 1'b0);
        push(MR | RDM | INC, 1'b1);
        push(RI, 1'b0);
        case (op)
            4'h1: begin
                push(REM, 1'b0);
                push(MR | RDM | INC, 1'b1);
                push(SEL | REM, 1'b0);
                push(SEL | MW, 1'b1);
            end
            4'h2, 4'h3, 4'h4, 4'h5: begin
                alu = (op == 4'h2) ? 14'd4 : (op == 4'h3) ? 14'd0 : (op == 4'h4) ? 14'd1 : 14'd2;
                push(REM, 1'b0);
                push(MR | RDM | INC, 1'b1);
                push(SEL | REM, 1'b0);
                push(SEL | MR | RDM, 1'b1);
                push(AC | NZ | alu, 1'b0);
            end
            4'h6: push(AC | NZ | 14'd3, 1'b0);
            4'h8, 4'h9, 4'hA: begin
                if (op == 4'h8 || (op == 4'h9 && fn3) || (op == 4'hA && fz3)) begin
                    push(REM, 1'b0);
                    push(MR | RDM, 1'b1);
                    push(LPC, 1'b0);
                end else begin
                    push(INC, 1'b0);
                end
            end
            default: push(14'h0, 1'b0);
        endcase
    endfunction

    task automatic run_instr(input logic [3:0] op, input int abort_at);
        bit          fn3, fz3, rdy;
        logic [13:0] e;
        int          k = 0;
        int          cyc = 0;
        fn3 = 1'($urandom);
        fz3 = 1'($urandom);
        build(op, fn3, fz3);
        opcode = op;
        while (exp_q.size() > 0) begin
            e = exp_q[0];
            rdy = 1'b1;
`ifdef CU_MEM_WAIT_EN
            rdy = ($urandom_range(0, 2) != 0);
`endif
            mem_ready = rdy;
            if (k == 3) begin
                flag_n = fn3;
                flag_z = fz3;
            end else begin
                flag_n = 1'($urandom);
                flag_z = 1'($urandom);
            end
            if (cyc == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check($sformatf("rst_abort_op%h", op), obs, 14'h0);
                @(posedge clk);
                #1 rst = 1'b0;
                exp_q.delete();
                mem_q.delete();
                return;
            end
            @(negedge clk);
            if (mem_q[0] && !rdy) begin
                check($sformatf("stall_op%h_s%0d", op, k), obs, e & ~INC);
            end else begin
                check($sformatf("op%h_s%0d", op, k), obs, e);
                void'(exp_q.pop_front());
                void'(mem_q.pop_front());
                k++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_random(input int n);
        logic [3:0] op;
        int         abort_at;
        for (int i = 0; i < n; i++) begin
            op = 4'($urandom_range(0, 14));
            abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1;
            run_instr(op, abort_at);
        end
    endtask

    initial begin
        rst = 1'b1;
        opcode = 4'h0;
        flag_n = 1'b0;
        flag_z = 1'b0;
        mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("reset_outputs", obs, 14'h0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        run_instr(4'h0, -1);
        run_instr(4'h0, -1);
        run_instr(4'h3, -1);
        run_instr(4'h1, -1);
        run_instr(4'h9, -1);
        run_instr(4'h9, -1);
        run_instr(4'hA, -1);
        run_instr(4'h8, -1);
        run_instr(4'h6, -1);
        run_random(150);

        run_instr(4'hF, -1);
        for (int i = 0; i < 20; i++) begin
            flag_n = 1'($urandom);
            flag_z = 1'($urandom);
            @(negedge clk);
            check("halt_hold", obs, HLT);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("halt_rst", obs, 14'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        run_instr(4'h2, -1);
        run_random(50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
